bram_dot_engine: RTL and testbench
==================================

Name: bram_dot_engine

Overview:
- Master-side sequencer that feeds and consumes the team's 32-bit byte-addressed BRAM models.
- Streams LEN words from two input BRAMs (X and W) in lock-step. Each word holds four signed int8 lanes.
- Accumulates the lane-wise dot product, writes the 32-bit result into an output BRAM (Y), then raises done.
- done drives the BRAMs' done input, which triggers the output-file dump in simulation.

Parameters:
- BRAM_ADDR_WIDTH, 15, byte-address width of every BRAM port (8192 words).
- LEN_WIDTH, 14, width of len; max legal len = 8192.
- OUT_ADDR, 0, byte address in Y where the result is written (word aligned).

Ports:
- clk  in  1  single clock, also drives all attached BRAM_CLK inputs.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; launches a job when in IDLE.
- len  in  LEN_WIDTH  number of words to process; sampled with start.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  job complete; held until next accepted start.
- result  out  32  final accumulator value, valid while done=1.
- X_ADDR, W_ADDR  out  BRAM_ADDR_WIDTH  byte addresses to the X and W BRAMs (always equal).
- X_EN, W_EN  out  1  BRAM enables.
- X_WE, W_WE  out  4  tied 4'h0.
- X_RDDATA, W_RDDATA  in  32  BRAM read data.
- Y_ADDR  out  BRAM_ADDR_WIDTH  byte address to the Y BRAM.
- Y_EN  out  1  enable for Y.
- Y_WE  out  4  byte write enables for Y.
- Y_WRDATA  out  32  write data to Y.

Behaviour:
- Reset (async, rstn=0): state=IDLE; busy=0, done=0, result=0.
- Reset also forces: all *_ADDR=0, *_EN=0, Y_WE=0, Y_WRDATA=0; accumulator, counters and valid pipe cleared.
- Reset mid-job aborts immediately with no Y write. BRAM RST inputs are tied 0 at top level.
- BRAM read latency is 2 cycles: address presented in cycle k appears on *_RDDATA in cycle k+2, provided EN is high in cycles k and k+1. X_EN and W_EN stay high continuously from the first address through the last data beat.
- FSM states and transitions:
  - IDLE: start=1 with len>0 → FETCH; start=1 with len=0 → WRITE with accumulator 0.
  - FETCH: issues byte addresses 0,4,8,…,4*(len-1), one per cycle. Leaves after len cycles → DRAIN.
  - DRAIN: 2 cycles, no new addresses → WRITE.
  - WRITE: exactly 1 cycle. Y_EN=1, Y_WE=4'hF, Y_ADDR=OUT_ADDR, Y_WRDATA=accumulator → DONE.
  - DONE: done=1, result=accumulator. start=1 clears done and launches a new job as from IDLE, same cycle rules.
- Valid pipe: a 2-deep shift register tags issued addresses. The accumulator updates at the clock edge ending each cycle in which the tag is valid.
- Arithmetic:
  - Lane i = bits [8i+7:8i], signed int8.
  - Beat sum = Σ over i=0..3 of sx(X lane) * sx(W lane): 16-bit signed products, 18-bit sum, sign-extended to 32 bits.
  - Accumulator: 32-bit two's complement, wraps on overflow with no saturation.
- Latency: start sampled at edge of cycle 0 → FETCH in cycles 1..len → DRAIN in len+1, len+2 → WRITE in len+3 → done=1 from cycle len+4. For len=0, WRITE is in cycle 1 and done=1 from cycle 2.
- start while busy=1 is ignored; len is not resampled.
- len > 8192 is illegal; behaviour is undefined and need not be checked.
- Y_EN and Y_WE are 0 in every cycle except WRITE. X_EN and W_EN are 0 in IDLE, WRITE and DONE.

Test Plan:
- X[0]=0x01020304, W[0]=0x01010101, len=1 → single Y write in cycle 4 of 0x0000000A at OUT_ADDR; done=1 from cycle 5; result=10.
- X[0..3]=0x80808080, W[0..3]=0x80808080, len=4 → result 4*65536 = 0x00040000; X_ADDR sequence 0,4,8,12 in cycles 1–4; done from cycle 8.
- X[0]=0xFF7F0102, W[0]=0x017F0203, len=1 → (-1)(1) + 127*127 + 1*2 + 2*3 = 16136 = 0x00003F08.
- len=0 → Y written with 0x00000000 in cycle 1, no X/W enables ever asserted, done=1 at cycle 2.
- Pulse start again in cycle 3 of a len=4 job → ignored. Final result identical to an undisturbed run; exactly one Y write.
- Deassert rstn in cycle 3 of a len=8 job → all outputs 0 asynchronously, Y never written. After release, start with len=2 produces the correct result.

Source files
------------

// File: rtl/bram_dot_engine_if.sv
// Bundle of the dot-engine control handshake plus the X/W/Y BRAM ports.
// master = engine side, slave = environment (controller and BRAM models).
interface bram_dot_engine_if #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LEN_WIDTH       = 14
);
  logic                       start;
  logic [LEN_WIDTH-1:0]       len;
  logic                       busy;
  logic                       done;
  logic [31:0]                result;
  logic [BRAM_ADDR_WIDTH-1:0] X_ADDR;
  logic [BRAM_ADDR_WIDTH-1:0] W_ADDR;
  logic                       X_EN;
  logic                       W_EN;
  logic [3:0]                 X_WE;
  logic [3:0]                 W_WE;
  logic [31:0]                X_RDDATA;
  logic [31:0]                W_RDDATA;
  logic [BRAM_ADDR_WIDTH-1:0] Y_ADDR;
  logic                       Y_EN;
  logic [3:0]                 Y_WE;
  logic [31:0]                Y_WRDATA;

  modport master (
    input  start, len, X_RDDATA, W_RDDATA,
    output busy, done, result, X_ADDR, W_ADDR, X_EN, W_EN, X_WE, W_WE,
           Y_ADDR, Y_EN, Y_WE, Y_WRDATA
  );

  modport slave (
    output start, len, X_RDDATA, W_RDDATA,
    input  busy, done, result, X_ADDR, W_ADDR, X_EN, W_EN, X_WE, W_WE,
           Y_ADDR, Y_EN, Y_WE, Y_WRDATA
  );
endinterface

// File: rtl/bram_dot_engine.sv
// Streams len words from the X and W BRAMs in lock-step, accumulates the
// signed int8 x4 dot product and writes the 32-bit result to the Y BRAM.
module bram_dot_engine #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LEN_WIDTH       = 14,
  parameter int OUT_ADDR        = 0
) (
  input  logic               clk,
  input  logic               rstn,
  bram_dot_engine_if.master  bus
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] OUT_ADDR_C = BRAM_ADDR_WIDTH'(OUT_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                     state_q;
  logic [LEN_WIDTH-1:0]       cnt_q;
  logic                       drain_q;
  logic [1:0]                 vld_q;
  logic [31:0]                acc_q;
  logic [31:0]                acc_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q;
  logic                       rd_en_q;
  logic                       busy_q;
  logic                       done_q;
  logic [31:0]                result_q;
  logic [BRAM_ADDR_WIDTH-1:0] y_addr_q;
  logic                       y_en_q;
  logic [3:0]                 y_we_q;
  logic [31:0]                y_wrdata_q;

  // Lane-wise signed product sum of the current beat, folded into the accumulator.
  always_comb begin : beat_calc
    logic signed [7:0]  xa;
    logic signed [7:0]  wa;
    logic signed [15:0] prod;
    logic signed [17:0] sum;
    xa   = '0;
    wa   = '0;
    prod = '0;
    sum  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      xa   = bus.X_RDDATA[8*i +: 8];
      wa   = bus.W_RDDATA[8*i +: 8];
      prod = 16'(xa) * 16'(wa);
      sum  = sum + 18'(prod);
    end
    acc_d = vld_q[1] ? acc_q + 32'(sum) : acc_q;
  end

  // Sequencer FSM with registered outputs; vld_q tags addresses through the 2-cycle BRAM read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      vld_q      <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      y_addr_q   <= '0;
      y_en_q     <= 1'b0;
      y_we_q     <= '0;
      y_wrdata_q <= '0;
    end else begin
      vld_q <= {vld_q[0], state_q == S_FETCH};
      acc_q <= acc_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            done_q <= 1'b0;
            busy_q <= 1'b1;
            acc_q  <= '0;
            vld_q  <= '0;
            if (bus.len != '0) begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
              addr_q  <= '0;
              cnt_q   <= bus.len - LEN_WIDTH'(1);
            end else begin
              state_q    <= S_WRITE;
              y_en_q     <= 1'b1;
              y_we_q     <= '1;
              y_addr_q   <= OUT_ADDR_C;
              y_wrdata_q <= '0;
            end
          end
        end
        S_FETCH: begin
          if (cnt_q == '0) begin
            state_q <= S_DRAIN;
            drain_q <= 1'b0;
          end else begin
            addr_q <= addr_q + BRAM_ADDR_WIDTH'(4);
            cnt_q  <= cnt_q - LEN_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            // last beat lands on this edge, so write acc_d rather than acc_q
            state_q    <= S_WRITE;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            y_en_q     <= 1'b1;
            y_we_q     <= '1;
            y_addr_q   <= OUT_ADDR_C;
            y_wrdata_q <= acc_d;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q    <= S_DONE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          result_q   <= acc_q;
          y_en_q     <= 1'b0;
          y_we_q     <= '0;
          y_addr_q   <= '0;
          y_wrdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.X_ADDR   = addr_q;
  assign bus.W_ADDR   = addr_q;
  assign bus.X_EN     = rd_en_q;
  assign bus.W_EN     = rd_en_q;
  assign bus.X_WE     = '0;
  assign bus.W_WE     = '0;
  assign bus.Y_ADDR   = y_addr_q;
  assign bus.Y_EN     = y_en_q;
  assign bus.Y_WE     = y_we_q;
  assign bus.Y_WRDATA = y_wrdata_q;

endmodule

// File: tb/tb_bram_dot_engine.sv
// Bench for bram_dot_engine: BRAM models with 2-cycle read latency, a
// cycle-accurate timing expectation per job and an arithmetic reference model.
module tb_bram_dot_engine;

  localparam int AW   = 15;
  localparam int LW   = 14;
  localparam int OUTA = 'h40;

  logic clk;
  logic rstn;
  int   n_err;
  int   n_chk;

  bram_dot_engine_if #(.BRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  bram_dot_engine #(
    .BRAM_ADDR_WIDTH(AW),
    .LEN_WIDTH      (LW),
    .OUT_ADDR       (OUTA)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM contents and read pipelines
  logic [31:0] X_mem [0:8191];
  logic [31:0] W_mem [0:8191];
  logic [31:0] x_s1 = '0, x_s2 = '0, w_s1 = '0, w_s2 = '0;
  int          y_cnt = 0;
  logic [31:0] y_last_data = '0;
  logic [AW-1:0] y_last_addr = '0;

  always @(posedge clk) begin
    if (bus.X_EN) begin
      x_s1 <= X_mem[bus.X_ADDR[AW-1:2]];
      x_s2 <= x_s1;
    end
    if (bus.W_EN) begin
      w_s1 <= W_mem[bus.W_ADDR[AW-1:2]];
      w_s2 <= w_s1;
    end
    if (bus.Y_EN && bus.Y_WE != 4'h0) begin
      y_cnt       <= y_cnt + 1;
      y_last_addr <= bus.Y_ADDR;
      y_last_data <= bus.Y_WRDATA;
    end
  end

  assign bus.X_RDDATA = x_s2;
  assign bus.W_RDDATA = w_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Dot product over the first n words, plain integer arithmetic (wraps at 32 bits).
  function automatic logic [31:0] ref_dot(input int unsigned n);
    int acc;
    logic signed [7:0] a, b;
    acc = 0;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned l = 0; l < 4; l++) begin
        a   = X_mem[i][8*l +: 8];
        b   = W_mem[i][8*l +: 8];
        acc = acc + int'(a) * int'(b);
      end
    end
    return acc;
  endfunction

  task automatic fill_random(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      X_mem[i] = $urandom;
      W_mem[i] = $urandom;
    end
  endtask

  task automatic fill_const(input int unsigned n, input logic [31:0] xv, input logic [31:0] wv);
    for (int unsigned i = 0; i < n; i++) begin
      X_mem[i] = xv;
      W_mem[i] = wv;
    end
  endtask

  // Launch one job and check every cycle up to two past the write cycle.
  // poke=1 re-pulses start (with len=0) in cycle 3, which must be ignored.
  task automatic run_job(input int unsigned n, input logic [31:0] exp, input bit poke);
    int unsigned wc;
    int          y0;
    wc = (n == 0) ? 1 : n + 3;
    y0 = y_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LW'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.len   = LW'($urandom);
    for (int unsigned c = 1; c <= wc + 2; c++) begin
      @(negedge clk);
      if (poke && c == 3) begin
        bus.start = 1'b1;
        bus.len   = '0;
      end
      if (poke && c == 4) bus.start = 1'b0;
      chk($sformatf("x_en n=%0d c=%0d", n, c), 32'(bus.X_EN), 32'(n > 0 && c <= n + 2));
      chk($sformatf("w_en n=%0d c=%0d", n, c), 32'(bus.W_EN), 32'(n > 0 && c <= n + 2));
      if (c <= n) begin
        chk($sformatf("x_addr n=%0d c=%0d", n, c), 32'(bus.X_ADDR), 4 * (c - 1));
        chk($sformatf("w_addr n=%0d c=%0d", n, c), 32'(bus.W_ADDR), 4 * (c - 1));
      end
      chk($sformatf("y_en n=%0d c=%0d", n, c), 32'(bus.Y_EN), 32'(c == wc));
      chk($sformatf("y_we n=%0d c=%0d", n, c), 32'(bus.Y_WE), (c == wc) ? 32'hF : 32'h0);
      if (c == wc) begin
        chk($sformatf("y_addr n=%0d", n), 32'(bus.Y_ADDR), OUTA);
        chk($sformatf("y_wrdata n=%0d", n), bus.Y_WRDATA, exp);
      end
      chk($sformatf("busy n=%0d c=%0d", n, c), 32'(bus.busy), 32'(c <= wc));
      chk($sformatf("done n=%0d c=%0d", n, c), 32'(bus.done), 32'(c > wc));
    end
    chk($sformatf("result n=%0d", n), bus.result, exp);
    chk($sformatf("y_writes n=%0d", n), y_cnt - y0, 1);
    chk($sformatf("y_mem_addr n=%0d", n), 32'(y_last_addr), OUTA);
    chk($sformatf("y_mem_data n=%0d", n), y_last_data, exp);
    chk($sformatf("xw_we n=%0d", n), {24'h0, bus.X_WE, bus.W_WE}, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},   32'(bus.busy),   0);
    chk({tag, " done"},   32'(bus.done),   0);
    chk({tag, " result"}, bus.result,      0);
    chk({tag, " x_addr"}, 32'(bus.X_ADDR), 0);
    chk({tag, " w_addr"}, 32'(bus.W_ADDR), 0);
    chk({tag, " xw_en"},  {30'h0, bus.X_EN, bus.W_EN}, 0);
    chk({tag, " y_addr"}, 32'(bus.Y_ADDR), 0);
    chk({tag, " y_en"},   32'(bus.Y_EN),   0);
    chk({tag, " y_we"},   32'(bus.Y_WE),   0);
    chk({tag, " y_wrdata"}, bus.Y_WRDATA,  0);
  endtask

  initial begin
    int          y0;
    int unsigned n;
    n_err     = 0;
    n_chk     = 0;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.len   = '0;
    for (int unsigned i = 0; i < 8192; i++) begin
      X_mem[i] = '0;
      W_mem[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // directed cases
    X_mem[0] = 32'h01020304;
    W_mem[0] = 32'h01010101;
    run_job(1, 32'h0000000A, 1'b0);
    fill_const(4, 32'h80808080, 32'h80808080);
    run_job(4, 32'h00040000, 1'b0);
    X_mem[0] = 32'hFF7F0102;
    W_mem[0] = 32'h017F0203;
    run_job(1, 32'h00003F08, 1'b0);
    run_job(0, 32'h00000000, 1'b0);
    fill_const(4, 32'h80808080, 32'h80808080);
    run_job(4, 32'h00040000, 1'b1);

    // reset in cycle 3 of a len=8 job aborts without a Y write
    fill_random(8);
    y0 = y_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LW'(8);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (12) @(negedge clk);
    chk("abort y_writes", y_cnt - y0, 0);
    chk_all_zero("abort_hold");
    rstn = 1'b1;
    fill_random(2);
    run_job(2, ref_dot(2), 1'b0);

    // randomized jobs against the reference model
    for (int unsigned k = 0; k < 8; k++) begin
      n = $urandom_range(1, 40);
      fill_random(n);
      run_job(n, ref_dot(n), 1'b0);
    end
    fill_random(8192);
    run_job(8192, ref_dot(8192), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
